// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit memory between a two-beat instruction fetch and a data port.
// Data has fixed priority; define ARB_STARVE_EN to let a waiting fetch win after STARVE_MAX data grants.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [15:0]       dm_wdata,
   output logic              dm_gnt,
   output logic              dm_valid,
   output logic [15:0]       dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata
);
   typedef enum logic [1:0] {IDLE, DM_RSP, IF_HI, IF_RSP} state_t;
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_lo;
   logic              r_kill;
   logic              w_if_win;
`ifdef ARB_STARVE_EN
   localparam int CW = ($clog2(STARVE_MAX + 1) < 3) ? 3 : $clog2(STARVE_MAX + 1);
   logic [CW-1:0] r_starve;
   assign w_if_win = if_req && !if_flush && (!dm_req || r_starve == CW'(STARVE_MAX));
   always_ff @(posedge clk) begin
      if (rst) r_starve <= '0;
      else if (r_state == IDLE)
         r_starve <= (!if_req || if_gnt) ? '0 :
                     (dm_gnt && r_starve != CW'(STARVE_MAX)) ? r_starve + CW'(1) : r_starve;
   end
`else
   assign w_if_win = if_req && !if_flush && !dm_req;
`endif
   // Outputs are forced low while rst is held so no access or pulse escapes during reset.
   always_comb begin
      w_next    = r_state;
      if_gnt    = 1'b0;
      if_valid  = 1'b0;
      if_instr  = '0;
      dm_gnt    = 1'b0;
      dm_valid  = 1'b0;
      dm_rdata  = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst)
         case (r_state)
            IDLE:
               if (w_if_win) begin
                  if_gnt   = 1'b1;
                  mem_en   = 1'b1;
                  mem_addr = if_addr;
                  w_next   = IF_HI;
               end else if (dm_req) begin
                  dm_gnt    = 1'b1;
                  mem_en    = 1'b1;
                  mem_we    = dm_wr;
                  mem_addr  = dm_addr;
                  mem_wdata = dm_wdata;
                  w_next    = DM_RSP;
               end
            DM_RSP: begin
               dm_valid = 1'b1;
               dm_rdata = mem_rdata;
               w_next   = IDLE;
            end
            IF_HI: begin
               mem_en   = 1'b1;
               mem_addr = r_addr + ADDR_W'(1);
               w_next   = IF_RSP;
            end
            default: begin
               if_valid = !r_kill && !if_flush;
               if_instr = {mem_rdata, r_lo};
               w_next   = IDLE;
            end
         endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_lo    <= '0;
         r_kill  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (if_gnt) r_addr <= if_addr;
         if (r_state == IF_HI) r_lo <= mem_rdata;
         r_kill <= (r_state == IF_HI) && (r_kill || if_flush);
      end
   end
endmodule
